decryption_dispatcher: RTL
==========================

Name: decryption_dispatcher

Overview:
- Scheduler between the upstream character stream and three decryption engines: engine 0 caesar, engine 1 scytale, engine 2 zigzag.
- Latches the algorithm select at the start of each message and routes every character to the chosen engine.
- Applies back-pressure while that engine is busy or draining.
- Multiplexes the selected engine's result stream back onto a single registered output.

Parameters:
- D_WIDTH, 8, character width in bits.
- END_TOKEN, 8'hFA, end-of-message character; it is forwarded to the engine and closes the message.
- DRAIN_TIMEOUT, 255, maximum DRAIN cycles allowed without a result before a forced return to IDLE.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_i  input  D_WIDTH  incoming character.
- valid_i  input  1  data_i qualifier.
- sel_i  input  2  algorithm select (0 caesar, 1 scytale, 2 zigzag, 3 invalid); sampled only on the first character of a message.
- busy_o  output  1  back-pressure to upstream; valid_i must be low while it is high.
- eng_data_o  output  D_WIDTH  character broadcast to all engines.
- eng_valid_o  output  3  one-hot valid, bit n = engine n.
- eng_busy_i  input  3  per-engine busy.
- eng_res_data_i  input  3*D_WIDTH  engine results, engine n in bits [n*D_WIDTH +: D_WIDTH].
- eng_res_valid_i  input  3  per-engine result valid.
- data_o  output  D_WIDTH  decrypted character.
- valid_o  output  1  data_o qualifier.
- err_o  output  1  one-cycle pulse when a message is dropped (invalid select or timeout).
- msg_len_o  output  16  characters forwarded in the last completed message, END_TOKEN included.

Behaviour:
- Reset, asynchronous, rst_n low: state=IDLE.
  - busy_o=0, eng_valid_o=0, eng_data_o=0, data_o=0, valid_o=0, err_o=0, msg_len_o=0.
  - Latched select=0, character counter=0, timeout counter=0.
  - Reset mid-message aborts the message at once; the engines are not told. Results arriving after reset are ignored until a new message starts.
- State IDLE:
  - valid_i=1 with sel_i in 0..2: latch sel, forward the character, counter=1. Go to ROUTE, or to DRAIN if data_i==END_TOKEN.
  - valid_i=1 with sel_i=3: go to DISCARD and pulse err_o one cycle later. Nothing is forwarded.
- State ROUTE:
  - Each valid_i: forward the character, increment the counter (saturates at 16'hFFFF).
  - data_i==END_TOKEN: forward it, then go to DRAIN.
  - sel_i is ignored.
- State DISCARD: swallow characters until END_TOKEN is swallowed, then go to IDLE. busy_o=0 throughout.
- State DRAIN:
  - busy_o=1.
  - Leave for IDLE on the first cycle the selected engine's eng_busy_i=0, sampled no earlier than 2 cycles after the END_TOKEN is forwarded. On that transition msg_len_o<=counter.
  - Timeout counter increments every DRAIN cycle with no selected-engine result and clears on any result.
  - Timeout counter reaching DRAIN_TIMEOUT forces IDLE with an err_o pulse; msg_len_o is left unchanged.
- Forwarding:
  - Registered, 1-cycle latency: valid_i at edge t gives eng_valid_o[sel]=1 and eng_data_o=data_i after edge t+1, held one cycle.
  - eng_valid_o bits of non-selected engines stay 0.
- busy_o:
  - Registered.
  - In ROUTE: busy_o=eng_busy_i[sel] registered, 1-cycle lag. It is also 1 for the whole of DRAIN.
  - If valid_i=1 while busy_o=1, the character is dropped, not forwarded, not counted, and no err_o pulse is generated.
- Result mux:
  - In ROUTE and DRAIN: data_o<=eng_res_data_i[sel], valid_o<=eng_res_valid_i[sel]. Registered, 1-cycle latency.
  - Results from non-selected engines are ignored in every state; all results are ignored in IDLE and DISCARD.
  - data_o holds its last value when valid_o=0.
- Simultaneous events:
  - A result and a new forwarded character in the same cycle are both handled.
  - END_TOKEN arriving while busy_o=1 is dropped, and the message stays in ROUTE.

Test Plan:
- Caesar message: sel_i=0, chars 8'h48, 8'h49, 8'hFA, engine 0 model with key 3 -> eng_valid_o=3'b001 each cycle after a char; data_o sequence 8'h45, 8'h46, 8'hF7; msg_len_o=3 after DRAIN; busy_o returns to 0.
- Select switching: message with sel_i=2, then sel_i=1 on the second message, sel_i toggled mid-message -> routing follows only the latched select; eng_valid_o=3'b100 then 3'b010.
- Invalid select: sel_i=3, chars 8'h41, 8'hFA -> no eng_valid_o; a single err_o pulse; state back to IDLE; msg_len_o unchanged.
- Back-pressure: eng_busy_i[1]=1 mid-message and upstream drives valid_i anyway -> busy_o=1 one cycle later; the offending char is not forwarded and not counted.
- Drain timeout: engine never asserts a result, DRAIN_TIMEOUT=4 -> exit to IDLE after 4 DRAIN cycles with an err_o pulse.
- Reset mid-message: rst_n low during ROUTE -> all outputs 0 asynchronously; a subsequent engine result is ignored; a new message routes correctly.

Source files
------------

// File: rtl/decryption_dispatcher.sv
// Routes an upstream character stream to one of three decryption engines and
// multiplexes the selected engine's results back onto a single registered output.
module decryption_dispatcher #(
    parameter int unsigned         D_WIDTH       = 8,
    parameter logic [D_WIDTH-1:0]  END_TOKEN     = D_WIDTH'('hFA),
    parameter int unsigned         DRAIN_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [D_WIDTH-1:0]     data_i,
    input  logic                   valid_i,
    input  logic [1:0]             sel_i,
    output logic                   busy_o,
    output logic [D_WIDTH-1:0]     eng_data_o,
    output logic [2:0]             eng_valid_o,
    input  logic [2:0]             eng_busy_i,
    input  logic [3*D_WIDTH-1:0]   eng_res_data_i,
    input  logic [2:0]             eng_res_valid_i,
    output logic [D_WIDTH-1:0]     data_o,
    output logic                   valid_o,
    output logic                   err_o,
    output logic [15:0]            msg_len_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ROUTE   = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    localparam logic [15:0] TMO_LAST = 16'(DRAIN_TIMEOUT - 1);

    logic [1:0]         state;
    logic [1:0]         sel_q;
    logic [15:0]        cnt;
    logic [15:0]        tmo;
    logic               armed;

    // Engine vectors padded to four entries so a 2-bit select indexes them safely.
    logic [3:0]         busy_ext;
    logic [3:0]         rv_ext;
    logic [D_WIDTH-1:0] res_arr [4];

    assign busy_ext = {1'b0, eng_busy_i};
    assign rv_ext   = {1'b0, eng_res_valid_i};

    always_comb begin
        for (int unsigned n = 0; n < 3; n++) begin
            res_arr[n] = eng_res_data_i[n*D_WIDTH +: D_WIDTH];
        end
        res_arr[3] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            sel_q       <= '0;
            cnt         <= '0;
            tmo         <= '0;
            armed       <= 1'b0;
            busy_o      <= 1'b0;
            eng_data_o  <= '0;
            eng_valid_o <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            err_o       <= 1'b0;
            msg_len_o   <= '0;
        end else begin
            eng_valid_o <= '0;
            err_o       <= 1'b0;

            if (state == S_ROUTE || state == S_DRAIN) begin
                valid_o <= rv_ext[sel_q];
                if (rv_ext[sel_q]) begin
                    data_o <= res_arr[sel_q];
                end
            end else begin
                valid_o <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (valid_i) begin
                        if (sel_i != 2'd3) begin
                            sel_q       <= sel_i;
                            eng_data_o  <= data_i;
                            eng_valid_o <= 3'b001 << sel_i;
                            cnt         <= 16'd1;
                            if (data_i == END_TOKEN) begin
                                state  <= S_DRAIN;
                                busy_o <= 1'b1;
                                tmo    <= '0;
                                armed  <= 1'b0;
                            end else begin
                                state  <= S_ROUTE;
                                busy_o <= busy_ext[sel_i];
                            end
                        end else begin
                            state <= S_DISCARD;
                            err_o <= 1'b1;
                        end
                    end
                end

                S_ROUTE: begin
                    busy_o <= busy_ext[sel_q];
                    if (valid_i && !busy_o) begin
                        eng_data_o  <= data_i;
                        eng_valid_o <= 3'b001 << sel_q;
                        if (cnt != 16'hFFFF) begin
                            cnt <= cnt + 16'd1;
                        end
                        if (data_i == END_TOKEN) begin
                            state  <= S_DRAIN;
                            busy_o <= 1'b1;
                            tmo    <= '0;
                            armed  <= 1'b0;
                        end
                    end
                end

                S_DISCARD: begin
                    if (valid_i && data_i == END_TOKEN) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    // armed blocks the busy sample on the first DRAIN cycle after END_TOKEN.
                    armed <= 1'b1;
                    if (armed && !busy_ext[sel_q]) begin
                        state     <= S_IDLE;
                        busy_o    <= 1'b0;
                        msg_len_o <= cnt;
                        tmo       <= '0;
                    end else if (rv_ext[sel_q]) begin
                        tmo <= '0;
                    end else if (tmo == TMO_LAST) begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                        err_o  <= 1'b1;
                        tmo    <= '0;
                    end else begin
                        tmo <= tmo + 16'd1;
                    end
                end
            endcase
        end
    end

endmodule
